key_led_sched: RTL and testbench

Scheduler that shares one LED between NUM_KEY debounced key requesters. Each debouncer's single-cycle key_flag pulse is latched as a pending request. An arbiter grants one pending key at a time, and the granted key's index is signalled on the LED as (index+1) blinks followed by a quiet gap. The block sits between the key_debounce instances and the board LED, replacing the single-key led_ctl path.

---
 rtl/key_led_sched.sv | 155 +++++++++++++++
 tb/tb_key_led_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_led_sched.sv
// Shares one LED between NUM_KEY debounced keys: latches key pulses, grants one at a time,
// and blinks the LED (grant index + 1) times followed by a quiet gap. Optional macro: KEY_LED_RR_EN.
module key_led_sched #(
  parameter int unsigned NUM_KEY = 4,
  parameter int unsigned ON_CYC  = 10_000_000,
  parameter int unsigned OFF_CYC = 10_000_000,
  parameter int unsigned GAP_CYC = 25_000_000
) (
  input  logic                       sclk,
  input  logic                       s_rst,
  input  logic [NUM_KEY-1:0]         key_flag,
  output logic                       led,
  output logic                       busy,
  output logic [$clog2(NUM_KEY)-1:0] grant_id,
  output logic [NUM_KEY-1:0]         pend
);

  localparam int unsigned IW    = $clog2(NUM_KEY);
  localparam int unsigned MAX01 = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned MAXC  = (MAX01 > GAP_CYC) ? MAX01 : GAP_CYC;
  localparam int unsigned CW    = $clog2(MAXC + 1);
  localparam int unsigned BW    = $clog2(NUM_KEY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic [IW-1:0]       gid_q, gid_d;
  logic [NUM_KEY-1:0]  pend_q, pend_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic [NUM_KEY-1:0]  clr_c;
  logic [IW-1:0]       win_c;
  logic [IW-1:0]       ridx_c;

`ifdef KEY_LED_RR_EN
  logic [IW-1:0]       last_q, last_d;
  logic                found_c;

  // Round-robin: scan from last+1 upward, wrapping, first pending key wins.
  always_comb begin
    win_c   = '0;
    ridx_c  = '0;
    found_c = 1'b0;
    for (int k = 1; k <= int'(NUM_KEY); k++) begin
      ridx_c = IW'((int'(last_q) + k) % int'(NUM_KEY));
      if (!found_c && pend_q[ridx_c]) begin
        win_c   = ridx_c;
        found_c = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    win_c  = '0;
    ridx_c = '0;
    for (int k = int'(NUM_KEY) - 1; k >= 0; k--) begin
      ridx_c = IW'(k);
      if (pend_q[ridx_c]) win_c = ridx_c;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    blink_d = blink_q;
    gid_d   = gid_q;
    clr_c   = '0;
`ifdef KEY_LED_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|pend_q) begin
          state_d      = ON;
          gid_d        = win_c;
          clr_c[win_c] = 1'b1;
          blink_d      = '0;
`ifdef KEY_LED_RR_EN
          last_d       = win_c;
`endif
        end
      end
      ON: begin
        if (cnt_q == CW'(ON_CYC - 1)) begin
          state_d = OFF;
          cnt_d   = '0;
        end
      end
      OFF: begin
        if (cnt_q == CW'(OFF_CYC - 1)) begin
          cnt_d   = '0;
          blink_d = blink_q + BW'(1);
          if (blink_d == BW'(gid_q) + BW'(1)) state_d = GAP;
          else                                  state_d = ON;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A new pulse beats a same-cycle grant clear, so the request re-queues.
    pend_d = (pend_q & ~clr_c) | key_flag;
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blink_q <= '0;
      gid_q   <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef KEY_LED_RR_EN
      last_q  <= IW'(NUM_KEY - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      gid_q   <= gid_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
`ifdef KEY_LED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign pend     = pend_q;

endmodule

// File: tb/tb_key_led_sched.sv
// Bench for key_led_sched: table-driven single-key trace, hand-written corner sequences,
// and a grant scoreboard checking order, blink count, service length and idle gap.
module tb_key_led_sched;

  localparam int unsigned NK  = 4;
  localparam int unsigned ONC = 4;
  localparam int unsigned OFC = 3;
  localparam int unsigned GPC = 5;

  logic          sclk;
  logic          s_rst;
  logic [NK-1:0] key_flag;
  logic          led;
  logic          busy;
  logic [1:0]    grant_id;
  logic [NK-1:0] pend;

  key_led_sched #(
    .NUM_KEY (NK),
    .ON_CYC  (ONC),
    .OFF_CYC (OFC),
    .GAP_CYC (GPC)
  ) dut (
    .sclk     (sclk),
    .s_rst    (s_rst),
    .key_flag (key_flag),
    .led      (led),
    .busy     (busy),
    .grant_id (grant_id),
    .pend     (pend)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic [3:0] kf;
    logic       led;
    logic       busy;
    logic [3:0] pend;
    logic [1:0] gid;
  } vec_t;

  int   checks;
  int   failures;
  int   exp_q[$];

  logic rst_seen;
  logic prev_busy;
  logic prev_led;
  logic in_svc;
  logic pend_at_end;
  int   svc_len;
  int   blinks;
  int   idle_len;
  int   cur_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant scoreboard, run once per cycle after outputs settle.
  task automatic monitor();
    int e;
    if (rst_seen) begin
      in_svc      = 1'b0;
      pend_at_end = 1'b0;
      idle_len    = 0;
    end else begin
      if (busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(grant_id), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("grant_order", 32'(grant_id), 32'(e));
        end
        if (pend_at_end) chk("idle_gap", 32'(idle_len), 32'd1);
        in_svc  = 1'b1;
        svc_len = 0;
        blinks  = 0;
        cur_gid = int'(grant_id);
      end
      if (busy) begin
        svc_len++;
        if (led && !prev_led) blinks++;
      end
      if (!busy && prev_busy && in_svc) begin
        chk("blink_count", 32'(blinks), 32'(cur_gid + 1));
        chk("service_len", 32'(svc_len), 32'((cur_gid + 1) * (ONC + OFC) + GPC));
        in_svc      = 1'b0;
        pend_at_end = (pend != '0);
        idle_len    = 0;
      end
      if (!busy) idle_len++;
    end
    prev_busy = busy;
    prev_led  = led;
  endtask

  task automatic tick();
    @(posedge sclk);
    rst_seen = s_rst;
    #1;
    monitor();
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!busy && pend == '0) done = 1'b1;
    end
    chk("wait_idle_timeout", 32'(done), 32'd1);
  endtask

  vec_t tab [30];

  initial begin
    int  c;
    logic stray;
    checks      = 0;
    failures    = 0;
    prev_busy   = 1'b0;
    prev_led    = 1'b0;
    in_svc      = 1'b0;
    pend_at_end = 1'b0;
    svc_len     = 0;
    blinks      = 0;
    idle_len    = 0;
    cur_gid     = 0;
    rst_seen    = 1'b1;
    s_rst       = 1'b1;
    key_flag    = '0;

    for (int i = 0; i < 30; i++) begin
      c = i + 1;
      tab[i].kf   = (i == 0) ? 4'b0100 : 4'b0000;
      tab[i].led  = ((c >= 2) && (c <= 5)) || ((c >= 9) && (c <= 12)) || ((c >= 16) && (c <= 19));
      tab[i].busy = (c >= 2) && (c <= 27);
      tab[i].pend = (c == 1) ? 4'b0100 : 4'b0000;
      tab[i].gid  = (c >= 2) ? 2'd2 : 2'd0;
    end

    // Reset state
    tick();
    tick();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    s_rst = 1'b0;
    tick();

    // Single key 2, cycle-exact trace
    exp_q.push_back(2);
    for (int i = 0; i < 30; i++) begin
      key_flag = tab[i].kf;
      tick();
      chk($sformatf("t1_led_c%0d", i + 1), 32'(led), 32'(tab[i].led));
      chk($sformatf("t1_busy_c%0d", i + 1), 32'(busy), 32'(tab[i].busy));
      chk($sformatf("t1_pend_c%0d", i + 1), 32'(pend), 32'(tab[i].pend));
      chk($sformatf("t1_gid_c%0d", i + 1), 32'(grant_id), 32'(tab[i].gid));
    end

    // All four keys at once
    key_flag = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    tick();
    key_flag = '0;
    chk("t2_pend", 32'(pend), 32'hF);
    wait_idle(300);

    // Keys 0 and 2 arrive while key 1 is served
    key_flag = 4'b0010;
    exp_q.push_back(1);
    tick();
    key_flag = '0;
    repeat (4) tick();
    key_flag = 4'b0101;
`ifdef KEY_LED_RR_EN
    exp_q.push_back(2);
    exp_q.push_back(0);
`else
    exp_q.push_back(0);
    exp_q.push_back(2);
`endif
    tick();
    key_flag = '0;
    wait_idle(300);

    // Key 3 re-presses twice during its own GAP
    key_flag = 4'b1000;
    exp_q.push_back(3);
    tick();
    key_flag = '0;
    repeat (29) tick();
    chk("t4_gap_led", 32'(led), 32'd0);
    chk("t4_gap_busy", 32'(busy), 32'd1);
    exp_q.push_back(3);
    key_flag = 4'b1000;
    tick();
    key_flag = '0;
    tick();
    key_flag = 4'b1000;
    tick();
    key_flag = '0;
    chk("t4_pend_once", 32'(pend), 32'h8);
    wait_idle(200);
    chk("t4_end_pend", 32'(pend), 32'd0);
    chk("t4_end_busy", 32'(busy), 32'd0);

    // Pulse on the grant cycle re-queues key 0
    key_flag = 4'b0001;
    exp_q.push_back(0);
    exp_q.push_back(0);
    tick();
    tick();
    key_flag = '0;
    chk("t5_pend_kept", 32'(pend), 32'h1);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_idle(200);

    // Reset mid-blink with requests pending
    key_flag = 4'b1000;
    exp_q.push_back(3);
    tick();
    key_flag = '0;
    tick();
    tick();
    chk("t6_led_on", 32'(led), 32'd1);
    key_flag = 4'b1010;
    tick();
    key_flag = '0;
    chk("t6_pend_pre", 32'(pend), 32'hA);
    chk("t6_led_pre", 32'(led), 32'd1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("t6_led", 32'(led), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pend", 32'(pend), 32'd0);
    chk("t6_gid", 32'(grant_id), 32'd0);
    stray = 1'b0;
    repeat (20) begin
      tick();
      stray = stray | busy | (|pend);
    end
    chk("t6_no_grant", 32'(stray), 32'd0);
    key_flag = 4'b0100;
    exp_q.push_back(2);
    tick();
    key_flag = '0;
    wait_idle(200);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
